// File: rtl/count_to_thermo_14_pkg.sv
// thermo_pkg: shared constants, types and helpers for the count-to-thermometer
// expander and its 2-entry buffer.
//   N_BITS  : expanded vector width, also the largest legal count (14)
//   CNT_W   : count width; 2**CNT_W must exceed N_BITS
//   DEPTH   : buffer entries (fixed at 2)
//   MAX_CNT : N_BITS as a CNT_W-wide value, the clamp ceiling
//   occ_e   : buffer occupancy state (EMPTY / ONE / FULL)
// Helpers: clamp_count, thermometer, rotl (rotl is used only when
// THERMO_ROTATE_EN is defined).
package thermo_pkg;

    localparam int N_BITS = 14;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 2;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(N_BITS);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Saturate a raw count to the largest value the vector can hold.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        return (c > MAX_CNT) ? MAX_CNT : c;
    endfunction

    // LSB-first thermometer code: bit i is set when i < c.
    function automatic logic [N_BITS-1:0] thermometer(input logic [CNT_W-1:0] c);
        logic [N_BITS-1:0] v;
        for (int i = 0; i < N_BITS; i++) begin
            v[i] = (i < int'(c));
        end
        return v;
    endfunction

    // Rotate left within N_BITS. amt must be < N_BITS; the upper half of the
    // doubled vector shifted left is exactly the rotated word.
    function automatic logic [N_BITS-1:0] rotl(input logic [N_BITS-1:0] v,
                                               input logic [CNT_W-1:0]  amt);
        logic [2*N_BITS-1:0] d;
        d = {v, v} << amt;
        return d[2*N_BITS-1:N_BITS];
    endfunction

endpackage

// File: rtl/count_to_thermo_14_if.sv
// count_to_thermo_14_if: stream bundle for the count-to-thermometer expander.
//   in_valid / in_ready / in_count      : count words into the block
//   out_valid / out_ready / out_bits /
//   out_count                           : expanded words out of the block
//   dbg_occ                             : buffer occupancy state, observation only
// Modports: slave = the expander's view, master = the view of whoever drives
// counts in and consumes vectors out.
//
// Handshake: on either side a word transfers on a rising clock edge where
// valid and ready are both high. A source holding valid high keeps its data
// stable until the transfer; ready never depends combinationally on valid
// in this block.
interface count_to_thermo_14_if;
    import thermo_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CNT_W-1:0]  in_count;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out_bits;
    logic [CNT_W-1:0]  out_count;
    occ_e              dbg_occ;

    modport slave (
        input  in_valid, in_count, out_ready,
        output in_ready, out_valid, out_bits, out_count, dbg_occ
    );

    modport master (
        output in_valid, in_count, out_ready,
        input  in_ready, out_valid, out_bits, out_count, dbg_occ
    );

endinterface

// File: rtl/count_to_thermo_14_fifo2.sv
// thermo_fifo2: generic 2-entry valid/ready buffer built as a head/tail
// register pair. The head register feeds pop_data directly, so the output
// is a pure register and reads 0 when the buffer is empty.
//   clk, rst              : clock, asynchronous active-high reset
//   push_valid/ready/data : write side; push_ready = not full (state only)
//   pop_valid/ready/data  : read side; pop_valid = not empty
//   occ_state             : occupancy FSM state, for observation
module thermo_fifo2
    import thermo_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output occ_e         occ_state
);

    occ_e         state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push, pop;

    assign push_ready = (state_q != OCC_FULL);
    assign pop_valid  = (state_q != OCC_EMPTY);
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;
    assign pop_data   = head_q;
    assign occ_state  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Entries vacated by a pop are zeroed so the head reads 0 when empty.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({push, pop})
                    2'b11: head_d = push_data;
                    2'b10: begin
                        tail_d  = push_data;
                        state_d = OCC_FULL;
                    end
                    2'b01: begin
                        head_d  = '0;
                        state_d = OCC_EMPTY;
                    end
                    default: ;
                endcase
            end
            OCC_FULL: begin
                // push_ready is low here, so only a pop can happen.
                if (pop) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    state_d = OCC_ONE;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
                head_d  = '0;
                tail_d  = '0;
            end
        endcase
    end

endmodule

// File: rtl/count_to_thermo_14.sv
// count_to_thermo_14: expands a 4-bit population count (0..14) into a 14-bit
// thermometer vector with exactly that many ones. Counts above 14 are clamped
// to 14 and raise a sticky overflow flag. Words pass through a 2-entry buffer;
// an empty buffer shows a pushed word after one edge.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : count_to_thermo_14_if.slave (in_* / out_* streams, dbg_occ)
//   ovf_sticky : set when an accepted count exceeded 14
//   ovf_clr    : synchronous clear of ovf_sticky (a same-cycle set wins)
// Optional macro THERMO_ROTATE_EN: out_bits is the thermometer code rotated
// left by an offset that advances by out_count on every pop, spreading the
// ones round-robin across the lanes.
module count_to_thermo_14
    import thermo_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    count_to_thermo_14_if.slave         bus,
    output logic                        ovf_sticky,
    input  logic                        ovf_clr
);

    logic             push;
    logic [CNT_W-1:0] stored_count;

    assign push         = bus.in_valid & bus.in_ready;
    assign stored_count = clamp_count(bus.in_count);

    thermo_fifo2 #(.W(CNT_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (bus.in_valid),
        .push_ready (bus.in_ready),
        .push_data  (stored_count),
        .pop_valid  (bus.out_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (bus.out_count),
        .occ_state  (bus.dbg_occ)
    );

    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (push && (bus.in_count > MAX_CNT)) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

`ifdef THERMO_ROTATE_EN
    localparam logic [CNT_W:0] N_BITS_W = (CNT_W+1)'(N_BITS);

    logic             pop;
    logic [CNT_W-1:0] rot_q;
    logic [CNT_W:0]   rot_sum;

    assign pop     = bus.out_valid & bus.out_ready;
    // Offset and count are both <= 14, so one conditional subtract is a
    // complete mod-14 reduction.
    assign rot_sum = {1'b0, rot_q} + {1'b0, bus.out_count};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_q <= '0;
        end else if (pop) begin
            rot_q <= (rot_sum >= N_BITS_W) ? CNT_W'(rot_sum - N_BITS_W)
                                           : rot_sum[CNT_W-1:0];
        end
    end

    // Decoded from registers only; no input reaches out_bits combinationally.
    assign bus.out_bits = rotl(thermometer(bus.out_count), rot_q);
`else
    assign bus.out_bits = thermometer(bus.out_count);
`endif

endmodule
